// File: rtl/change_dispenser_pkg.sv
// ---------------------------------------------------------------------------
// change_dispenser_pkg
// Shared types and constants for the vending-machine change dispenser:
//   state_t        dispenser FSM state encoding
//   amount_t       change amount in rubles (0..4 fits in 3 bits)
//   COIN_1/COIN_2  coin denominations
//   WAIT_W         width of the ack wait counter
//   decode_amount  maps the give_* vend pulses to a ruble amount
// ---------------------------------------------------------------------------
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRINK,
    S_CHOOSE,
    S_EJECT,
    S_DONE,
    S_FAULT
  } state_t;

  typedef logic [2:0] amount_t;

  localparam amount_t COIN_1 = 3'd1;
  localparam amount_t COIN_2 = 3'd2;
  localparam int      WAIT_W = 4;

  // The largest requested amount wins when several give_* lines are high.
  function automatic amount_t decode_amount(input logic g1, input logic g2,
                                            input logic g3, input logic g4);
    if (g4)      return 3'd4;
    else if (g3) return 3'd3;
    else if (g2) return 3'd2;
    else if (g1) return 3'd1;
    else         return 3'd0;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// ---------------------------------------------------------------------------
// change_dispenser_if
// Actuator handshake bundle between the dispenser and the machine hardware.
//   drink_release  dispenser -> drink actuator request (held until drink_ack)
//   drink_ack      drink actuator done
//   eject_1        dispenser -> 1-ruble hopper request (held until coin_ack)
//   eject_2        dispenser -> 2-ruble hopper request (held until coin_ack)
//   coin_ack       shared hopper done
// master = dispenser side, slave = actuator side.
// ---------------------------------------------------------------------------
interface change_dispenser_if;
  logic drink_release;
  logic drink_ack;
  logic eject_1;
  logic eject_2;
  logic coin_ack;

  modport master (output drink_release, eject_1, eject_2,
                  input  drink_ack, coin_ack);
  modport slave  (input  drink_release, eject_1, eject_2,
                  output drink_ack, coin_ack);
endinterface

// File: rtl/change_dispenser_coin_counter.sv
// ---------------------------------------------------------------------------
// coin_counter
// Saturating up/down coin inventory counter, loaded with INIT on reset.
//   CLK     clock
//   reset   synchronous active-high, loads INIT
//   i_inc   +1 (holds at all-ones)
//   i_dec   -1 (holds at zero)
//   o_cnt   current count
// Simultaneous inc and dec leave the count unchanged.
// ---------------------------------------------------------------------------
module coin_counter #(
  parameter int CNT_W = 4,
  parameter int INIT  = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] MAX_V  = '1;
  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_cnt <= INIT_V;
    end else if (i_inc && !i_dec) begin
      if (r_cnt != MAX_V) r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Vending-machine back end: releases the drink, then pays change one coin at a
// time from 2-ruble and 1-ruble hoppers, tracking inventory.
//   CLK, reset            clock / synchronous active-high reset
//   take_ur_drink         vend pulse; give_{1..4}_*_back select change amount
//   act (master)          drink_release/drink_ack, eject_1/eject_2/coin_ack
//   refill_1, refill_2    +1 coin per cycle high
//   busy                  transaction in progress (also held in FAULT)
//   done, shortfall       end-of-transaction pulse and unpaid rubles
//   overflow, fault       sticky: vend dropped / ack timeout
//   coin1_cnt, coin2_cnt  coin inventories
// ---------------------------------------------------------------------------
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int COIN1_INIT  = 8,
  parameter int COIN2_INIT  = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 take_ur_drink,
  input  logic                 give_1_ruble_back,
  input  logic                 give_2_rubles_back,
  input  logic                 give_3_rubles_back,
  input  logic                 give_4_rubles_back,
  change_dispenser_if.master   act,
  input  logic                 refill_1,
  input  logic                 refill_2,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           shortfall,
  output logic                 overflow,
  output logic                 fault,
  output logic [CNT_W-1:0]     coin1_cnt,
  output logic [CNT_W-1:0]     coin2_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  state_t            r_state;
  amount_t           r_rem;
  logic              r_pend_valid;
  amount_t           r_pend_amt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_drink_release;
  logic              r_eject_1;
  logic              r_eject_2;
  logic              r_busy;
  logic              r_done;
  amount_t           r_shortfall;
  logic              r_overflow;
  logic              r_fault;

  amount_t           w_amount;
  logic              w_dec1;
  logic              w_dec2;
  logic [CNT_W-1:0]  w_coin1_cnt;
  logic [CNT_W-1:0]  w_coin2_cnt;

  assign w_amount = decode_amount(give_1_ruble_back, give_2_rubles_back,
                                  give_3_rubles_back, give_4_rubles_back);

  // A coin leaves the inventory on the cycle its hopper acknowledges.
  assign w_dec1 = (r_state == S_EJECT) && r_eject_1 && act.coin_ack;
  assign w_dec2 = (r_state == S_EJECT) && r_eject_2 && act.coin_ack;

  coin_counter #(.CNT_W(CNT_W), .INIT(COIN1_INIT)) u_coin1 (
    .CLK   (CLK),
    .reset (reset),
    .i_inc (refill_1),
    .i_dec (w_dec1),
    .o_cnt (w_coin1_cnt)
  );

  coin_counter #(.CNT_W(CNT_W), .INIT(COIN2_INIT)) u_coin2 (
    .CLK   (CLK),
    .reset (reset),
    .i_inc (refill_2),
    .i_dec (w_dec2),
    .o_cnt (w_coin2_cnt)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_rem           <= '0;
      r_pend_valid    <= 1'b0;
      r_pend_amt      <= '0;
      r_wait          <= '0;
      r_drink_release <= 1'b0;
      r_eject_1       <= 1'b0;
      r_eject_2       <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_shortfall     <= '0;
      r_overflow      <= 1'b0;
      r_fault         <= 1'b0;
    end else begin
      r_done <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          // A vend parked while finishing the previous one is served first.
          if (r_pend_valid || take_ur_drink) begin
            r_rem           <= r_pend_valid ? r_pend_amt : w_amount;
            r_pend_valid    <= r_pend_valid && take_ur_drink;
            r_pend_amt      <= w_amount;
            r_state         <= S_DRINK;
            r_drink_release <= 1'b1;
            r_wait          <= '0;
            r_busy          <= 1'b1;
          end
        end

        S_DRINK: begin
          if (act.drink_ack) begin
            r_drink_release <= 1'b0;
            r_state         <= S_CHOOSE;
          end else if (r_wait == WAIT_LAST) begin
            r_drink_release <= 1'b0;
            r_fault         <= 1'b1;
            r_state         <= S_FAULT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        S_CHOOSE: begin
          // Prefer 2-ruble coins; fall back to 1-ruble; otherwise report shortfall.
          if (r_rem >= COIN_2 && w_coin2_cnt != '0) begin
            r_eject_2 <= 1'b1;
            r_wait    <= '0;
            r_state   <= S_EJECT;
          end else if (r_rem >= COIN_1 && w_coin1_cnt != '0) begin
            r_eject_1 <= 1'b1;
            r_wait    <= '0;
            r_state   <= S_EJECT;
          end else begin
            r_done      <= 1'b1;
            r_shortfall <= r_rem;
            r_state     <= S_DONE;
          end
        end

        S_EJECT: begin
          if (act.coin_ack) begin
            r_rem     <= r_eject_2 ? (r_rem - COIN_2) : (r_rem - COIN_1);
            r_eject_1 <= 1'b0;
            r_eject_2 <= 1'b0;
            r_state   <= S_CHOOSE;
          end else if (r_wait == WAIT_LAST) begin
            r_eject_1 <= 1'b0;
            r_eject_2 <= 1'b0;
            r_fault   <= 1'b1;
            r_state   <= S_FAULT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        S_DONE: begin
          r_shortfall <= '0;
          if (r_pend_valid) begin
            r_rem           <= r_pend_amt;
            r_pend_valid    <= 1'b0;
            r_state         <= S_DRINK;
            r_drink_release <= 1'b1;
            r_wait          <= '0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        S_FAULT: begin
          // Only reset leaves FAULT.
        end

        default: r_state <= S_IDLE;
      endcase

      // Vends outside IDLE go to the pending slot. In DONE the slot is being
      // emptied this cycle, so the new vend may always take it; this is placed
      // after the case so it wins over the slot clear above.
      if (take_ur_drink && r_state != S_IDLE) begin
        if (r_state == S_FAULT) begin
          r_overflow <= 1'b1;
        end else if (r_state == S_DONE || !r_pend_valid) begin
          r_pend_valid <= 1'b1;
          r_pend_amt   <= w_amount;
        end else begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign act.drink_release = r_drink_release;
  assign act.eject_1       = r_eject_1;
  assign act.eject_2       = r_eject_2;
  assign busy              = r_busy;
  assign done              = r_done;
  assign shortfall         = r_shortfall;
  assign overflow          = r_overflow;
  assign fault             = r_fault;
  assign coin1_cnt         = w_coin1_cnt;
  assign coin2_cnt         = w_coin2_cnt;

endmodule
